// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns fetch_pc, issues single-outstanding imem requests, queues fetched words for decode.
// Defining FETCH_STATS_EN adds the stat_fetched / stat_flushed saturating counters.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instruction,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus_four,
  input  logic            predict_redirect,
  input  logic [XLEN-1:0] predict_target,
  input  logic            mispredict_redirect,
  input  logic [XLEN-1:0] mispredict_target
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_flushed
`endif
);
  localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              drop_pending_reg;
  logic              reset_q_reg;

  logic [31:0]       instr_mem [FQ_DEPTH];
  logic [XLEN-1:0]   pc_mem    [FQ_DEPTH];
  logic [XLEN-1:0]   pc4_mem   [FQ_DEPTH];

  logic              honour_predict, redirect, deq, enq, discard_resp;
  logic [XLEN-1:0]   redirect_pc;

  assign if_valid        = (count_reg != '0);
  assign if_instruction  = instr_mem[rd_ptr_reg];
  assign if_pc           = pc_mem[rd_ptr_reg];
  assign if_pc_plus_four = pc4_mem[rd_ptr_reg];
  assign imem_addr       = fetch_pc_reg;

  // A predict only counts for the instruction actually handed off, and a mispredict overrides it.
  assign honour_predict = predict_redirect && if_valid && if_ready && !mispredict_redirect;
  assign redirect       = mispredict_redirect || honour_predict;
  assign redirect_pc    = (mispredict_redirect ? mispredict_target : predict_target) & ~XLEN'(3);
  assign deq            = if_valid && if_ready && !mispredict_redirect;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    imem_req      = 1'b0;
    enq           = 1'b0;
    discard_resp  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        imem_req = !reset && (count_reg < CNT_W'(FQ_DEPTH)) && !predict_redirect
                   && !mispredict_redirect && !drop_pending_reg;
        if (imem_req) state_next = WAIT;
        discard_resp = drop_pending_reg && imem_rvalid;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_next = IDLE;
          if (redirect) begin
            discard_resp = 1'b1;
          end else begin
            enq           = 1'b1;
            fetch_pc_next = fetch_pc_reg + XLEN'(4);
          end
        end else if (redirect) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          discard_resp = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (redirect) fetch_pc_next = redirect_pc;
  end

  always_ff @(posedge clk) begin
    reset_q_reg <= reset;
    if (reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      // Remember a stale response only across a one-cycle reset; a held reset starts clean.
      drop_pending_reg <= ((state_reg != IDLE) || (drop_pending_reg && !reset_q_reg)) && !imem_rvalid;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (discard_resp) drop_pending_reg <= 1'b0;
      if (redirect) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        count_reg <= count_reg + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
      pc4_mem[wr_ptr_reg]   <= fetch_pc_reg + XLEN'(4);
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0]      fetched_reg, flushed_reg;
  logic [CNT_W-1:0] flush_entries;
  logic [32:0]      fetched_sum, flushed_sum;

  always_comb begin
    flush_entries = '0;
    if (mispredict_redirect)  flush_entries = count_reg;
    else if (honour_predict)  flush_entries = count_reg - CNT_W'(1);
  end

  assign fetched_sum = {1'b0, fetched_reg} + 33'(enq);
  assign flushed_sum = {1'b0, flushed_reg} + 33'(flush_entries) + 33'(discard_resp);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_reg <= '0;
      flushed_reg <= '0;
    end else begin
      fetched_reg <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      flushed_reg <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end

  assign stat_fetched = fetched_reg;
  assign stat_flushed = flushed_reg;
`endif

endmodule
